cv32e41p_apu_arbiter: RTL

- Shares one APU/FPU request/response channel between NUM_REQ requesters, e.g. several APU dispatchers or a core dispatcher plus an accelerator port.
- Arbitrates requests round-robin, holding the choice stable while the APU stalls.
- Records the order of granted requests in a tag FIFO.
- The APU returns results in order, so each result valid is routed back to the requester that issued it.

---
 rtl/cv32e41p_apu_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/cv32e41p_apu_arbiter.sv
// cv32e41p_apu_arbiter: round-robin sharing of one in-order APU channel between NUM_REQ requesters.
// Optional build macro CV32E41P_APU_ARB_PERF_EN adds the perf_conflict_o saturating counter.
module cv32e41p_apu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DEPTH   = 4,
    parameter int OP_W    = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0][OP_W-1:0]  op_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            rvalid_o,
    output logic                          apu_req_o,
    output logic [OP_W-1:0]               apu_op_o,
    input  logic                          apu_gnt_i,
    input  logic                          apu_rvalid_i,
    output logic                          busy_o,
    output logic                          full_o,
    output logic                          err_o
`ifdef CV32E41P_APU_ARB_PERF_EN
    ,
    output logic [31:0]                   perf_conflict_o
`endif
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]       state_q;
    logic [IDX_W-1:0] rr_q, lock_idx_q, rr_sel, sel;
    logic [IDX_W-1:0] tag_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q, found, empty, hs, zl, push, pop;

    // First requester at or above the rr pointer, wrapping around
    always_comb begin
        rr_sel = rr_q;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_i[(int'(rr_q) + k) % NUM_REQ]) begin
                rr_sel = IDX_W'((int'(rr_q) + k) % NUM_REQ);
                found  = 1'b1;
            end
        end
    end

    assign sel       = (state_q == LOCKED) ? lock_idx_q : rr_sel;
    assign empty     = (cnt_q == '0);
    assign full_o    = (cnt_q == CNT_W'(DEPTH));
    assign busy_o    = !empty;
    assign err_o     = err_q;
    assign apu_req_o = |req_i & !full_o;
    assign apu_op_o  = apu_req_o ? op_i[sel] : '0;
    assign hs        = apu_req_o & apu_gnt_i;
    assign zl        = apu_rvalid_i & empty & hs;
    assign pop       = apu_rvalid_i & !empty;
    assign push      = hs & !zl;
    assign gnt_o     = hs ? NUM_REQ'(1) << sel : '0;
    assign rvalid_o  = pop ? NUM_REQ'(1) << tag_q[rptr_q] : zl ? NUM_REQ'(1) << sel : '0;

    // Arbitration pointer, stall lock, in-order tag FIFO and sticky error
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            lock_idx_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
        end else begin
            if (hs) rr_q <= IDX_W'((int'(sel) + 1) % NUM_REQ);
            if (hs || (state_q == LOCKED && !req_i[lock_idx_q])) begin
                state_q <= IDLE;
            end else if (apu_req_o && !apu_gnt_i) begin
                state_q    <= LOCKED;
                lock_idx_q <= sel;
            end
            if (push) tag_q[wptr_q] <= sel;
            wptr_q <= wptr_q + PTR_W'(push);
            rptr_q <= rptr_q + PTR_W'(pop);
            cnt_q  <= cnt_q + CNT_W'(push) - CNT_W'(pop);
            err_q  <= err_q | (apu_rvalid_i & empty & !hs);
        end
    end

`ifdef CV32E41P_APU_ARB_PERF_EN
    logic conflict;
    assign conflict = ($countones(req_i) > 1) | (|req_i & !hs);

    // Saturating count of cycles with contention or an ungranted request
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) perf_conflict_o <= '0;
        else if (conflict && perf_conflict_o != '1) perf_conflict_o <= perf_conflict_o + 32'd1;
    end
`endif

endmodule
